// File: rtl/blk448_serializer_pkg.sv
// blk448_serializer_pkg: shared state encoding, block geometry and row-slice helper
package blk448_serializer_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;
  localparam int ROWS_PER_BLOCK = 4;
  localparam int PIX_PER_ROW = 4;
  function automatic int row_lsb(input int r, input int w);
    return (ROWS_PER_BLOCK - 1 - r) * PIX_PER_ROW * w;
  endfunction
endpackage

// File: rtl/blk448_row_mux.sv
// blk448_row_mux: combinational 4:1 selection of one row from the 16-pixel buffer
module blk448_row_mux
  import blk448_serializer_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH*16-1:0]           buf_i,
  input  logic [1:0]                         row_i,
  output logic [WORD_WIDTH*PIX_PER_ROW-1:0]  row_o
);
  logic [WORD_WIDTH*PIX_PER_ROW-1:0] rows [ROWS_PER_BLOCK];
  for (genvar g = 0; g < ROWS_PER_BLOCK; g++) begin : g_row
    assign rows[g] = buf_i[row_lsb(g, WORD_WIDTH) +: WORD_WIDTH*PIX_PER_ROW];
  end
  assign row_o = rows[row_i];
endmodule

// File: rtl/blk448_serializer.sv
// blk448_serializer: streams a parallel 4x4 pixel block out as four row words, row 0 first
module blk448_serializer
  import blk448_serializer_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_ROWS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_WIDTH*16-1:0] blk_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_WIDTH*4-1:0] out_data,
  output logic [1:0]              out_row,
  output logic                    out_last
);
  state_e                  state_q, state_d;
  logic [1:0]              row_q, row_d;
  logic [WORD_WIDTH*16-1:0] buf_q, buf_d;
  logic                    acc_in, acc_out;
  assign out_valid = !rst && state_q == ST_SEND;
  assign in_ready  = !rst && (state_q == ST_IDLE || (row_q == 2'd3 && out_ready));
  assign acc_in    = in_valid && in_ready;
  assign acc_out   = out_valid && out_ready;
  assign out_row   = row_q;
  assign out_last  = out_valid && row_q == 2'd3;
  blk448_row_mux #(.WORD_WIDTH(WORD_WIDTH)) u_mux (
    .buf_i (buf_q),
    .row_i (row_q),
    .row_o (out_data)
  );
  // next state: a new block always restarts at row 0; the last row without a successor returns to idle
  always_comb begin
    state_d = acc_in ? ST_SEND : (acc_out && row_q == 2'd3) ? ST_IDLE : state_q;
    row_d   = acc_in ? 2'd0 : acc_out ? row_q + 2'd1 : row_q;
    buf_d   = acc_in ? blk_in : buf_q;
  end
  // state, row counter and block buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
    end
  end
endmodule
